coreabc_ram256x16_port: RTL

Request-side controller for the CoreABC 256x16 RAM wrapper (RAM512X18, non-pipelined, one-cycle registered read). It accepts single-word read/write requests over a valid/ready handshake and drives the wrapper's WEN/REN/WADDR/RADDR/WD. It returns read data through a 3-entry response FIFO with backpressure. After reset it optionally clears all 256 words before accepting traffic.

---
 rtl/coreabc_ram_pkg.sv | 15 +
 rtl/coreabc_ram256x16_port_if.sv | 24 ++
 rtl/coreabc_rsp_fifo.sv | 46 ++++
 rtl/coreabc_ram256x16_port.sv | 87 ++++++++
 4 files changed

// File: rtl/coreabc_ram_pkg.sv
// coreabc_ram_pkg: shared widths, response depth, controller state type and pointer helper
package coreabc_ram_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int RSP_DEPTH = 3;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Advance a response FIFO pointer, wrapping from the last slot back to 0
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(RSP_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/coreabc_ram256x16_port_if.sv
// coreabc_ram256x16_port_if: request/response handshake bundle of the RAM port controller
interface coreabc_ram256x16_port_if;
   import coreabc_ram_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );

endinterface

// File: rtl/coreabc_rsp_fifo.sv
// coreabc_rsp_fifo: 3x16 response FIFO with a registered head word
module coreabc_rsp_fifo
   import coreabc_ram_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_empty,
   output logic [DATA_W-1:0] o_head
);

   logic [DATA_W-1:0] r_mem [RSP_DEPTH];
   logic [DATA_W-1:0] r_head;
   logic [1:0]        r_wptr, r_rptr, r_count, w_rptr_n, w_rem;
   logic              w_pop;

   assign o_full   = r_count == 2'(RSP_DEPTH);
   assign o_empty  = r_count == 2'd0;
   assign o_head   = r_head;
   assign w_pop    = i_pop & ~o_empty;
   assign w_rptr_n = w_pop ? ptr_inc(r_rptr) : r_rptr;
   assign w_rem    = r_count - 2'(w_pop);

   // storage array, written at the tail slot
   always_ff @(posedge i_clk)
      if (i_push) r_mem[r_wptr] <= i_din;

   // pointers, occupancy, and head word (bypass the pushed word when nothing older remains)
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 2'd0;
         r_head  <= '0;
      end else begin
         if (i_push) r_wptr <= ptr_inc(r_wptr);
         r_rptr  <= w_rptr_n;
         r_count <= w_rem + 2'(i_push);
         if (i_push && w_rem == 2'd0) r_head <= i_din;
         else if (w_rem != 2'd0) r_head <= r_mem[w_rptr_n];
      end

endmodule

// File: rtl/coreabc_ram256x16_port.sv
// coreabc_ram256x16_port: request-side controller for the CoreABC 256x16 RAM wrapper
module coreabc_ram256x16_port
   import coreabc_ram_pkg::*;
#(
   parameter bit              CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
   input  logic                     i_rwclk,
   input  logic                     i_reset_n,
   coreabc_ram256x16_port_if.slave  io_bus,
   output logic                     o_init_busy,
   output logic                     o_ram_wen,
   output logic                     o_ram_ren,
   output logic [ADDR_W-1:0]        o_ram_waddr,
   output logic [ADDR_W-1:0]        o_ram_raddr,
   output logic [DATA_W-1:0]        o_ram_wd,
   input  logic [DATA_W-1:0]        i_ram_rd
);

   state_t            r_state, w_state_n;
   logic [ADDR_W-1:0] r_cnt, r_waddr, r_raddr;
   logic [DATA_W-1:0] r_wd, w_head;
   logic [1:0]        r_outst;
   logic              r_inflight;
   logic              w_ready, w_clr, w_wr_acc, w_rd_acc;
   logic              w_pop, w_push, w_full, w_empty;

   // state register; reset lands in INIT only when the clear sequence is enabled
   always_ff @(posedge i_rwclk or negedge i_reset_n)
      if (!i_reset_n) r_state <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      else r_state <= w_state_n;

   // next state: leave INIT once the write at address 255 has been issued
   always_comb begin
      w_state_n = (r_state == ST_INIT && r_cnt == '1) ? ST_RUN : r_state;
   end

   // outputs: clear writes in INIT, single accepted request per cycle in RUN, idle ports hold last values
   always_comb begin
      w_ready     = i_reset_n & (r_state == ST_RUN) & (r_outst != 2'(RSP_DEPTH));
      w_wr_acc    = io_bus.req_valid & w_ready & io_bus.req_write;
      w_rd_acc    = io_bus.req_valid & w_ready & ~io_bus.req_write;
      w_clr       = i_reset_n & (r_state == ST_INIT);
      o_init_busy = r_state == ST_INIT;
      o_ram_wen   = w_clr | w_wr_acc;
      o_ram_ren   = w_rd_acc;
      o_ram_waddr = w_clr ? r_cnt : w_wr_acc ? io_bus.req_addr : r_waddr;
      o_ram_wd    = w_clr ? CLEAR_VALUE : w_wr_acc ? io_bus.req_wdata : r_wd;
      o_ram_raddr = w_rd_acc ? io_bus.req_addr : r_raddr;
   end

   assign w_pop            = ~w_empty & io_bus.rsp_ready;
   assign w_push           = r_inflight & (~w_full | w_pop);
   assign io_bus.req_ready = w_ready;
   assign io_bus.rsp_valid = ~w_empty;
   assign io_bus.rsp_rdata = w_head;

   // clear counter, outstanding-read count, read-in-flight flag and held RAM port values
   always_ff @(posedge i_rwclk or negedge i_reset_n)
      if (!i_reset_n) begin
         r_cnt      <= '0;
         r_outst    <= 2'd0;
         r_inflight <= 1'b0;
         r_waddr    <= '0;
         r_raddr    <= '0;
         r_wd       <= '0;
      end else begin
         r_cnt      <= (r_state == ST_RUN) ? '0 : r_cnt + ADDR_W'(1);
         r_outst    <= r_outst + 2'(w_rd_acc) - 2'(w_pop);
         r_inflight <= w_rd_acc;
         r_waddr    <= o_ram_waddr;
         r_raddr    <= o_ram_raddr;
         r_wd       <= o_ram_wd;
      end

   coreabc_rsp_fifo u_fifo (
      .i_clk   (i_rwclk),
      .i_rst_n (i_reset_n),
      .i_push  (w_push),
      .i_din   (i_ram_rd),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule
